// File: rtl/shapool_pkg.sv
// Shared types and constants for the SHA pool job controller.
package shapool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  // Last value of the 6-bit phase counter before it wraps to 0.
  localparam logic [5:0] PHASE_LAST = 6'd63;
  // Number of phase wraps needed before the pipeline delivers real results.
  localparam logic [1:0] FILL_DONE  = 2'd2;

  // One job record. nonce_count is carried at full 32-bit width so the
  // record type does not depend on the pool size parameter.
  typedef struct packed {
    logic [255:0] sha_state;
    logic [95:0]  message_head;
    logic [15:0]  difficulty_bm;
    logic [7:0]   nonce_start_MSB;
    logic [31:0]  nonce_count;
  } job_t;

  // A zero count is illegal; treat it as a single pool iteration.
  function automatic logic [31:0] effective_count(input logic [31:0] count);
    return (count == 32'd0) ? 32'd1 : count;
  endfunction

endpackage

// File: rtl/shapool_job_slot.sv
// Single job-record register with load / clear / valid.
// Used for the active job and, when queuing is built in, for the shadow job.
module shapool_job_slot
  import shapool_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic clear,
  input  job_t job_in,
  output job_t job,
  output logic valid
);

  // Capture a job on load; clear only drops the valid flag.
  // NOTE: the payload is a plain register bank, not a RAM, so it can and
  // does take the asynchronous reset; the pool outputs read zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      job   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      job   <= job_in;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shapool_job_ctrl.sv
// Job controller for a pool of SHA-256 hashing units.
// Accepts a job, holds the pool in reset while loading, runs it for the
// requested number of pool iterations, and reports either a match or
// exhaustion. Optional build macro SHAPOOL_JOB_CTRL_QUEUE_EN adds a
// one-entry shadow job slot so the next job can be accepted at any time.
module shapool_job_ctrl
  import shapool_pkg::*;
#(
  parameter  int POOL_SIZE_LOG2 = 1,
  parameter  int NONCE_LAG      = 2,
  localparam int NONCE_WIDTH    = 32 - POOL_SIZE_LOG2
) (
  input  logic                   clk,
  input  logic                   reset_n,

  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [255:0]           job_sha_state,
  input  logic [95:0]            job_message_head,
  input  logic [15:0]            job_difficulty_bm,
  input  logic [7:0]             job_nonce_start_MSB,
  input  logic [NONCE_WIDTH-1:0] job_nonce_count,
  input  logic                   job_abort,

  output logic                   pool_reset_n,
  output logic [255:0]           pool_sha_state,
  output logic [95:0]            pool_message_head,
  output logic [15:0]            pool_difficulty_bm,
  output logic [7:0]             pool_nonce_start_MSB,
  input  logic                   pool_success,
  input  logic [NONCE_WIDTH-1:0] pool_nonce,

  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   result_found,
  output logic [NONCE_WIDTH-1:0] result_nonce
);

  state_t               state;
  state_t               state_next;

  job_t                 job_in;
  job_t                 act_job;
  job_t                 act_din;
  logic                 act_valid;
  logic                 act_load;
  logic                 act_clear;
  logic                 job_hs;

  logic [5:0]           phase;
  logic [1:0]           fill;
  logic [NONCE_WIDTH:0] hashes_done;
  logic [NONCE_WIDTH:0] hashes_inc;

  logic                 check_cycle;
  logic                 exhausted;
  logic                 finish;
  logic                 abort_now;
  logic                 leave;
  logic [NONCE_WIDTH-1:0] lagged_nonce;

  assign job_in = {job_sha_state, job_message_head, job_difficulty_bm,
                   job_nonce_start_MSB, 32'(job_nonce_count)};

  // Pool results are only meaningful once the pipeline has filled twice.
  assign check_cycle  = (state == ST_RUN) && act_valid &&
                        (phase == 6'd0) && (fill == FILL_DONE);
  assign hashes_inc   = hashes_done + 1'b1;
  assign exhausted    = 33'(hashes_inc) >= 33'(effective_count(act_job.nonce_count));
  assign finish       = check_cycle && (pool_success || exhausted);
  assign lagged_nonce = pool_nonce - NONCE_WIDTH'(NONCE_LAG);

  assign abort_now    = job_abort && ((state == ST_LOAD) || (state == ST_RUN));
  assign leave        = abort_now || ((state == ST_REPORT) && result_ready);

`ifdef SHAPOOL_JOB_CTRL_QUEUE_EN
  job_t sh_job;
  logic sh_valid;
  logic sh_load;
  logic promote;
  logic direct;

  // A job goes straight to the active slot when nothing is running (or the
  // running job is leaving with no shadow waiting); otherwise it is parked.
  assign job_hs   = job_valid && !sh_valid;
  assign promote  = leave && sh_valid;
  assign direct   = job_hs && ((state == ST_IDLE) || (leave && !sh_valid));
  assign sh_load  = job_hs && !direct;
  assign act_load = promote || direct;
  assign act_din  = promote ? sh_job : job_in;

  shapool_job_slot u_shadow_slot (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (sh_load),
    .clear  (promote),
    .job_in (job_in),
    .job    (sh_job),
    .valid  (sh_valid)
  );
`else
  assign job_hs   = job_valid && (state == ST_IDLE);
  assign act_load = job_hs;
  assign act_din  = job_in;
`endif

  assign act_clear = leave && !act_load;

  shapool_job_slot u_active_slot (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (act_load),
    .clear  (act_clear),
    .job_in (act_din),
    .job    (act_job),
    .valid  (act_valid)
  );

  assign pool_sha_state       = act_job.sha_state;
  assign pool_message_head    = act_job.message_head;
  assign pool_difficulty_bm   = act_job.difficulty_bm;
  assign pool_nonce_start_MSB = act_job.nonce_start_MSB;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state decode.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (act_load) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort_now) state_next = act_load ? ST_LOAD : ST_IDLE;
        else           state_next = ST_RUN;
      end
      ST_RUN: begin
        if (abort_now)   state_next = act_load ? ST_LOAD : ST_IDLE;
        else if (finish) state_next = ST_REPORT;
      end
      ST_REPORT: begin
        if (result_ready) state_next = act_load ? ST_LOAD : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Moore outputs; the pool runs only in RUN.
  always_comb begin
    pool_reset_n = (state == ST_RUN);
    result_valid = (state == ST_REPORT);
`ifdef SHAPOOL_JOB_CTRL_QUEUE_EN
    job_ready    = !sh_valid;
`else
    job_ready    = (state == ST_IDLE);
`endif
  end

  // Phase / fill / iteration counters, restarted for every loaded job.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase       <= '0;
      fill        <= '0;
      hashes_done <= '0;
    end else if (state == ST_LOAD) begin
      phase       <= '0;
      fill        <= '0;
      hashes_done <= '0;
    end else if (state == ST_RUN) begin
      phase <= phase + 6'd1;
      if ((phase == PHASE_LAST) && (fill != FILL_DONE)) fill <= fill + 2'd1;
      if (check_cycle) hashes_done <= hashes_inc;
    end
  end

  // Result capture on the finishing check cycle; held through REPORT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_found <= 1'b0;
      result_nonce <= '0;
    end else if (finish && !abort_now) begin
      result_found <= pool_success;
      result_nonce <= pool_success ? lagged_nonce : '0;
    end else if ((state == ST_REPORT) && result_ready) begin
      result_found <= 1'b0;
      result_nonce <= '0;
    end
  end

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// Self-checking bench for shapool_job_ctrl (default parameters).
// Expected results come from a timing model: check cycles fall at RUN
// cycle 128 + 64*j, the result appears 2 + 128 + 64*j cycles after the job
// handshake, and a hit reports (nonce - 2) mod 2^31.
module tb_shapool_job_ctrl;

  localparam int NW = 31;

`ifdef SHAPOOL_JOB_CTRL_QUEUE_EN
  localparam bit QUEUED = 1'b1;
`else
  localparam bit QUEUED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          job_valid;
  logic          job_ready;
  logic [255:0]  job_sha_state;
  logic [95:0]   job_message_head;
  logic [15:0]   job_difficulty_bm;
  logic [7:0]    job_nonce_start_MSB;
  logic [NW-1:0] job_nonce_count;
  logic          job_abort;
  logic          pool_reset_n;
  logic [255:0]  pool_sha_state;
  logic [95:0]   pool_message_head;
  logic [15:0]   pool_difficulty_bm;
  logic [7:0]    pool_nonce_start_MSB;
  logic          pool_success;
  logic [NW-1:0] pool_nonce;
  logic          result_valid;
  logic          result_ready;
  logic          result_found;
  logic [NW-1:0] result_nonce;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shapool_job_ctrl dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .job_valid           (job_valid),
    .job_ready           (job_ready),
    .job_sha_state       (job_sha_state),
    .job_message_head    (job_message_head),
    .job_difficulty_bm   (job_difficulty_bm),
    .job_nonce_start_MSB (job_nonce_start_MSB),
    .job_nonce_count     (job_nonce_count),
    .job_abort           (job_abort),
    .pool_reset_n        (pool_reset_n),
    .pool_sha_state      (pool_sha_state),
    .pool_message_head   (pool_message_head),
    .pool_difficulty_bm  (pool_difficulty_bm),
    .pool_nonce_start_MSB(pool_nonce_start_MSB),
    .pool_success        (pool_success),
    .pool_nonce          (pool_nonce),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .result_found        (result_found),
    .result_nonce        (result_nonce)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    job_valid = 1'b0; job_abort = 1'b0; result_ready = 1'b0;
    pool_success = 1'b0; pool_nonce = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Offer a randomized job while idle; returns at the LOAD-cycle negedge.
  task automatic start_job(input string tag, input logic [NW-1:0] count);
    job_sha_state       = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
    job_message_head    = {$urandom, $urandom, $urandom};
    job_difficulty_bm   = 16'($urandom);
    job_nonce_start_MSB = 8'($urandom);
    job_nonce_count     = count;
    job_valid           = 1'b1;
    check({tag, "_ready_idle"}, job_ready, 1'b1);
    @(negedge clk);
    job_valid = 1'b0;
    check({tag, "_load_pool_reset_n"}, pool_reset_n, 1'b0);
  endtask

  // Full job: run, compare against the model, hold the result, release it.
  task automatic run_job(input string tag, input logic [NW-1:0] count, input int hit_j,
                         input logic [NW-1:0] hit_nonce, input int decoy_a,
                         input int decoy_b, input int hold);
    int            eff, j, exp_lat, hit_k, cyc;
    bit            exp_found, run_ok;
    logic [NW-1:0] exp_nonce;
    logic [255:0]  sha_copy;

    eff = (count == '0) ? 1 : int'(count);
    if (hit_j >= 0 && hit_j < eff) begin
      j = hit_j; exp_found = 1'b1; exp_nonce = hit_nonce - NW'(2);
    end else begin
      j = eff - 1; exp_found = 1'b0; exp_nonce = '0;
    end
    exp_lat = 2 + 128 + 64 * j;
    hit_k   = (hit_j >= 0) ? 128 + 64 * hit_j : -1;

    start_job(tag, count);
    sha_copy = job_sha_state;
    run_ok = 1'b1;
    cyc = 0;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (result_valid) break;
      if (pool_reset_n !== 1'b1 || pool_sha_state !== sha_copy) run_ok = 1'b0;
      pool_success = ((cyc - 1) == hit_k) || ((cyc - 1) == decoy_a) || ((cyc - 1) == decoy_b);
      pool_nonce   = ((cyc - 1) == hit_k) ? hit_nonce : NW'($urandom);
    end
    pool_success = 1'b0;

    check({tag, "_run_pool_active"}, run_ok, 1'b1);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_found"}, result_found, exp_found);
    check({tag, "_nonce"}, result_nonce, exp_nonce);
    check({tag, "_report_pool_reset_n"}, pool_reset_n, 1'b0);
    check({tag, "_pool_head"}, pool_message_head, job_message_head);
    check({tag, "_pool_diff"}, {pool_difficulty_bm, pool_nonce_start_MSB},
          {job_difficulty_bm, job_nonce_start_MSB});

    // Hold the result; aborts and new jobs must not disturb it.
    for (int h = 0; h < hold; h++) begin
      job_valid = 1'b1;
      job_abort = 1'b1;
      if (h == 0) check({tag, "_ready_in_report"}, job_ready, QUEUED);
      @(negedge clk);
      check({tag, "_hold_valid"}, result_valid, 1'b1);
      check({tag, "_hold_found"}, result_found, exp_found);
      check({tag, "_hold_nonce"}, result_nonce, exp_nonce);
    end
    job_valid = 1'b0;
    job_abort = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, "_released_valid"}, result_valid, 1'b0);
    check({tag, "_released_ready"}, job_ready, 1'b1);
    apply_reset();
  endtask

  initial begin
    int saw_result;
    reset_n = 1'b0;
    job_valid = 1'b0; job_abort = 1'b0; result_ready = 1'b0;
    pool_success = 1'b0; pool_nonce = '0;
    job_sha_state = '0; job_message_head = '0; job_difficulty_bm = '0;
    job_nonce_start_MSB = '0; job_nonce_count = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_pool_reset_n", pool_reset_n, 1'b0);
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_result", {result_found, result_nonce}, '0);
    check("rst_pool_fields", {pool_sha_state, pool_message_head, pool_difficulty_bm,
                              pool_nonce_start_MSB}, '0);

    // Exhaustion after four iterations, no pool match.
    run_job("exhaust4", NW'(4), -1, '0, -1, -1, 0);
    // First check cycle hit; result held for ten cycles.
    run_job("hit_first", NW'(4), 0, NW'(32'h10), -1, -1, 10);
    // Strobes before the pipeline has filled and off-phase are ignored.
    run_job("ignored", NW'(2), -1, '0, 5, 64, 0);
    // Zero count behaves as one iteration.
    run_job("zero_count", NW'(0), -1, '0, 17, -1, 0);

    // Abort at RUN cycle 70.
    start_job("abort", NW'(5));
    repeat (71) @(negedge clk);
    job_abort = 1'b1;
    @(negedge clk);
    job_abort = 1'b0;
    check("abort_job_ready", job_ready, 1'b1);
    check("abort_pool_reset_n", pool_reset_n, 1'b0);
    check("abort_result_valid", result_valid, 1'b0);
    saw_result = 0;
    repeat (300) begin
      @(negedge clk);
      if (result_valid) saw_result++;
    end
    check("abort_no_result", saw_result, 0);
    apply_reset();

    // Asynchronous reset mid-RUN, observed before any clock edge.
    start_job("async_rst", NW'(3));
    repeat (51) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_pool_reset_n", pool_reset_n, 1'b0);
    check("arst_result", {result_valid, result_found, result_nonce}, '0);
    check("arst_job_ready", job_ready, 1'b1);
    check("arst_pool_fields", {pool_sha_state, pool_difficulty_bm}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Randomized jobs against the model, including nonce wrap-around.
    for (int r = 0; r < 8; r++) begin
      logic [NW-1:0] hn;
      hn = ($urandom_range(0, 1) == 0) ? NW'($urandom_range(0, 3)) : NW'($urandom);
      run_job($sformatf("rand%0d", r), NW'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)) - 1, hn,
              int'($urandom_range(0, 127)), 129 + int'($urandom_range(0, 62)),
              int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
